// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if
// Bundles the fetch sequencer's control inputs, instruction-memory port and
// issue-side outputs.
//   master : the fetch sequencer. It drives imem_addr, instr, instr_pc,
//            instr_valid, halted and fetch_count. It receives start, stall,
//            redirect_valid, redirect_target and imem_data.
//   slave  : the surrounding core and memory, with the opposite directions.
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              start;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              halted;
  logic [15:0]       fetch_count;

  modport master (
    input  start, stall, redirect_valid, redirect_target, imem_data,
    output imem_addr, instr, instr_pc, instr_valid, halted, fetch_count
  );

  modport slave (
    output start, stall, redirect_valid, redirect_target, imem_data,
    input  imem_addr, instr, instr_pc, instr_valid, halted, fetch_count
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
// Instruction-fetch sequencer for the 256-word instruction memory. It owns the
// PC, addresses memory directly from the PC register, and latches the returned
// word into an issue register tagged with its PC.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; forces IDLE and clears all state
//   bus   : imem_fetch_ctrl_if.master
//           start/stall/redirect in, imem_addr/imem_data memory port,
//           and instr/instr_pc/instr_valid/halted/fetch_count out.
// A redirect takes priority over a stall, and a stall takes priority over a
// fetch. A word whose opcode equals HALT_OPCODE is never issued. It parks the
// sequencer in HALT with the PC still pointing at the halt word.
module imem_fetch_ctrl #(
  parameter int              ADDR_W      = 8,
  parameter int              DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
  parameter logic [5:0]      HALT_OPCODE = 6'b111111
) (
  input  logic               clk,
  input  logic               reset,
  imem_fetch_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              halted_q, halted_d;
  logic [15:0]       fetch_count_q, fetch_count_d;
  logic              is_halt_word;

  assign is_halt_word = (bus.imem_data[DATA_W-1 -: 6] == HALT_OPCODE);

  // Next-state and next-output computation for the fetch sequencer
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (bus.redirect_valid) begin
          // Redirect wins even over stall; the slot becomes a bubble.
          pc_d          = bus.redirect_target;
          instr_valid_d = 1'b0;
        end else if (bus.stall) begin
          state_d = ST_RUN;
        end else if (is_halt_word) begin
          // Halt word is not issued. The PC stays on it.
          state_d       = ST_HALT;
          instr_valid_d = 1'b0;
          halted_d      = 1'b1;
        end else begin
          instr_d       = bus.imem_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          // PC wraps modulo 2^ADDR_W by natural truncation.
          pc_d          = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (fetch_count_q != 16'hFFFF) begin
            fetch_count_d = fetch_count_q + 16'd1;
          end else begin
            fetch_count_d = fetch_count_q;
          end
        end
      end

      ST_HALT: begin
        if (bus.redirect_valid) begin
          state_d  = ST_RUN;
          pc_d     = bus.redirect_target;
          halted_d = 1'b0;
        end else begin
          state_d = ST_HALT;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        instr_valid_d = 1'b0;
        halted_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= {ADDR_W{1'b0}};
      instr_q       <= {DATA_W{1'b0}};
      instr_pc_q    <= {ADDR_W{1'b0}};
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.halted      = halted_q;
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;
  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  imem_fetch_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .RESET_PC(8'd0), .HALT_OPCODE(6'b111111)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(ifc)
  );

  logic [DW-1:0] mem [0:255];
  assign ifc.imem_data = mem[ifc.imem_addr];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic        start;
    logic        stall;
    logic        rv;
    logic [7:0]  rt;
    logic        e_valid;
    logic        e_halted;
    logic [7:0]  e_addr;
    logic [15:0] e_fc;
    logic [7:0]  e_ipc;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic s, input logic st, input logic rv,
                              input logic [7:0] rt, input logic v, input logic h,
                              input logic [7:0] a, input logic [15:0] fc,
                              input logic [7:0] ipc);
    vec_t r;
    r.start = s; r.stall = st; r.rv = rv; r.rt = rt;
    r.e_valid = v; r.e_halted = h; r.e_addr = a; r.e_fc = fc; r.e_ipc = ipc;
    return r;
  endfunction

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic drive(input logic s, input logic st, input logic rv, input logic [7:0] rt);
    ifc.start = s; ifc.stall = st; ifc.redirect_valid = rv; ifc.redirect_target = rt;
    @(posedge clk);
    #1;
  endtask

  // Reference model: architectural view of the sequencer
  bit          m_running, m_halted, m_valid;
  logic [7:0]  m_pc, m_ipc;
  logic [31:0] m_instr;
  int          m_cnt;

  task automatic model_step(input logic s, input logic st, input logic rv, input logic [7:0] rt);
    logic [31:0] w;
    if (m_halted) begin
      if (rv) begin m_halted = 0; m_running = 1; m_pc = rt; end
    end else if (!m_running) begin
      if (s) begin m_running = 1; m_pc = 8'd0; end
    end else if (rv) begin
      m_pc = rt; m_valid = 0;
    end else if (!st) begin
      w = mem[m_pc];
      if (w[31:26] == 6'h3F) begin
        m_running = 0; m_halted = 1; m_valid = 0;
      end else begin
        m_instr = w; m_ipc = m_pc; m_valid = 1;
        m_pc = 8'((int'(m_pc) + 1) % 256);
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      end
    end
  endtask

  initial begin
    logic [65:0] got_t, exp_t;
    vec_t v;
    reset = 1'b1;
    ifc.start = 1'b0; ifc.stall = 1'b0; ifc.redirect_valid = 1'b0; ifc.redirect_target = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h00A0_0000 | 32'(i);
    mem[0]  = 32'h0C01_0023;
    mem[1]  = 32'h0401_0000;
    mem[2]  = 32'h0C01_002F;
    mem[14] = 32'hFC00_0000;

    // Reset state
    #12;
    check("rst_valid",  96'(ifc.instr_valid), 96'(1'b0));
    check("rst_addr",   96'(ifc.imem_addr),   96'(8'd0));
    check("rst_fc",     96'(ifc.fetch_count), 96'(16'd0));
    check("rst_halted", 96'(ifc.halted),      96'(1'b0));
    check("rst_instr",  96'(ifc.instr),       96'(32'd0));
    check("rst_ipc",    96'(ifc.instr_pc),    96'(8'd0));
    reset = 1'b0;

    // Redirect and stall are ignored in IDLE
    drive(1'b0, 1'b1, 1'b1, 8'd50);
    check("idle_addr",  96'(ifc.imem_addr),   96'(8'd0));
    check("idle_valid", 96'(ifc.instr_valid), 96'(1'b0));

    //            start stall rv  rt      valid halt addr    fc      ipc
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 8'd0,   16'd0, 8'd0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 8'd1,   16'd1, 8'd0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 8'd2,   16'd2, 8'd1);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 8'd2,   16'd2, 8'd1);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 8'd2,   16'd2, 8'd1);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 8'd2,   16'd2, 8'd1);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 8'd3,   16'd3, 8'd2);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 8'd13,  1'b0, 1'b0, 8'd13,  16'd3, 8'd0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 8'd14,  16'd4, 8'd13);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 8'd14,  16'd4, 8'd0);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 8'd14,  16'd4, 8'd0);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 1'b0, 8'd0,   16'd4, 8'd0);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 8'd1,   16'd5, 8'd0);
    tbl[13] = mk(1'b0, 1'b0, 1'b1, 8'd254, 1'b0, 1'b0, 8'd254, 16'd5, 8'd0);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 8'd255, 16'd6, 8'd254);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 8'd0,   16'd7, 8'd255);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 8'd1,   16'd8, 8'd0);

    for (int i = 0; i < 17; i++) begin
      v = tbl[i];
      drive(v.start, v.stall, v.rv, v.rt);
      check($sformatf("v%0d_valid", i),  96'(ifc.instr_valid), 96'(v.e_valid));
      check($sformatf("v%0d_halted", i), 96'(ifc.halted),      96'(v.e_halted));
      check($sformatf("v%0d_addr", i),   96'(ifc.imem_addr),   96'(v.e_addr));
      check($sformatf("v%0d_fc", i),     96'(ifc.fetch_count), 96'(v.e_fc));
      if (v.e_valid) begin
        check($sformatf("v%0d_ipc", i),   96'(ifc.instr_pc), 96'(v.e_ipc));
        check($sformatf("v%0d_instr", i), 96'(ifc.instr),    96'(mem[v.e_ipc]));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 8'd0);

    // Asynchronous reset between edges while an instruction is live
    #2 reset = 1'b1;
    #1;
    check("arst_valid",  96'(ifc.instr_valid), 96'(1'b0));
    check("arst_addr",   96'(ifc.imem_addr),   96'(8'd0));
    check("arst_fc",     96'(ifc.fetch_count), 96'(16'd0));
    check("arst_halted", 96'(ifc.halted),      96'(1'b0));
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 8'd0);
      check("arst_idle", 96'({ifc.instr_valid, ifc.imem_addr, ifc.fetch_count}), 96'({1'b0, 8'd0, 16'd0}));
    end
    drive(1'b1, 1'b0, 1'b0, 8'd0);
    drive(1'b0, 1'b0, 1'b0, 8'd0);
    check("arst_restart", 96'({ifc.instr_valid, ifc.instr_pc, ifc.instr, ifc.fetch_count}),
          96'({1'b1, 8'd0, mem[0], 16'd1}));

    // Randomized run against the reference model
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom();
      if ($urandom_range(0, 19) == 0) mem[i][31:26] = 6'h3F;
      else if (mem[i][31:26] == 6'h3F) mem[i][26] = 1'b0;
    end
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    m_running = 0; m_halted = 0; m_valid = 0; m_pc = 8'd0; m_ipc = 8'd0;
    m_instr = 32'd0; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      logic s, st, rv;
      logic [7:0] rt;
      s  = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 11) == 0);
      rt = 8'($urandom_range(0, 255));
      model_step(s, st, rv, rt);
      drive(s, st, rv, rt);
      exp_t = {m_valid, m_halted, m_pc, 16'(m_cnt),
               m_valid ? m_ipc : 8'd0, m_valid ? m_instr : 32'd0};
      got_t = {ifc.instr_valid, ifc.halted, ifc.imem_addr, ifc.fetch_count,
               ifc.instr_valid ? ifc.instr_pc : 8'd0, ifc.instr_valid ? ifc.instr : 32'd0};
      check($sformatf("rand_c%0d", c), 96'(got_t), 96'(exp_t));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer for the single-cycle MIPS32 core's 256-word instruction memory. It owns the program counter, drives the memory's 8-bit word address, and registers the returned 32-bit word into an issue register with valid, PC tag, stall, redirect (branch/jump/jr) and halt handling. It sits between the instruction memory and the decode/execute stage, and is the only block that addresses instruction memory.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width; PC width.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 8'd0: PC loaded by `start`.
- `HALT_OPCODE`, 6'b111111: opcode in bits [31:26] that marks a halt word.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse; begins fetching from `RESET_PC`.
- `stall` in 1: downstream not ready; freezes the issue register and PC.
- `redirect_valid` in 1: branch, jump or jr taken this cycle.
- `redirect_target` in ADDR_W: new PC, as a word address.
- `imem_addr` out ADDR_W: word address to instruction memory; equals the PC register.
- `imem_data` in DATA_W: combinational read data for `imem_addr`.
- `instr` out DATA_W: issued instruction.
- `instr_pc` out ADDR_W: address `instr` was fetched from.
- `instr_valid` out 1: `instr`/`instr_pc` hold a live instruction.
- `halted` out 1: high in HALT state.
- `fetch_count` out 16: number of instructions issued since reset; saturates at 16'hFFFF.

## Operation
- States: IDLE, RUN, HALT. Reset state is IDLE.
- Reset values: pc=0, instr=0, instr_pc=0, instr_valid=0, halted=0, fetch_count=0.
- IDLE:
  - `start` -> RUN, pc<=RESET_PC.
  - `stall` and `redirect_valid` are ignored.
- RUN, priority per edge is redirect > stall > fetch:
  - Redirect: pc<=redirect_target, instr_valid<=0, remain in RUN. This applies even when `stall`=1.
  - Stall (no redirect): pc, instr, instr_pc, instr_valid and fetch_count all hold.
  - Fetch, when imem_data[31:26] != HALT_OPCODE: instr<=imem_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1, fetch_count+=1 (saturating).
  - Fetch, when imem_data[31:26] == HALT_OPCODE: the word is not issued. Go to HALT; instr_valid<=0; pc holds at the halt address; fetch_count unchanged.
- HALT:
  - halted=1, instr_valid=0, pc holds.
  - `redirect_valid` -> RUN, pc<=redirect_target, halted<=0.
  - `start` and `stall` are ignored.
- `start` in RUN or HALT is ignored.
- PC arithmetic is modulo 2^ADDR_W: pc 255 + 1 -> 0, with no flag and no stop.
- Asserting `reset` mid-operation immediately forces reset values and IDLE, independent of `clk`.

## Timing
- `imem_addr` is a direct register output. No combinational path from any input to `imem_addr`.
- Fetch latency is 1 cycle: pc=A at cycle n gives instr=mem[A], instr_valid=1 from cycle n+1.
- Sequential throughput is 1 instruction per cycle when `stall`=0.
- `start` sampled at edge n: first valid instruction appears after edge n+1.
- Redirect sampled at edge k: exactly one bubble (instr_valid=0 after edge k); mem[target] is issued after edge k+1.
- Stall is level-sensitive. Issue resumes on the first edge with `stall`=0, with no lost or duplicated instruction.
- Halt word at pc=H fetched at edge h: halted=1 and instr_valid=0 after edge h. The preceding instruction was already issued at edge h-1.
- All outputs are registered.

## Test plan
- **Reset and sequential fetch.** Memory holds mem[0]=0x0C010023, mem[1]=0x04010000, mem[2]=0x0C01002F. Stimulus: assert reset, release, then pulse start. Required response: after the next three edges, (instr_pc, instr) = (0,0x0C010023), (1,0x04010000), (2,0x0C01002F); fetch_count=3.
- **Stall hold.** Stimulus: assert stall for 3 cycles while instr_pc=1 is issued. Required response: instr=0x04010000, instr_valid=1 and imem_addr=2 held for all 3 cycles; the next edge after release issues pc 2; fetch_count increments once only.
- **Redirect with stall.** Stimulus: redirect_valid=1, target=8'd13, stall=1 in the same cycle. Required response: next cycle instr_valid=0, imem_addr=13; the following cycle instr_pc=13, instr=mem[13].
- **Halt and restart.** Stimulus: mem[14]=0xFC000000; run sequentially through pc 13, then redirect to target=0 while in HALT. Required response: pc 13 is issued, then halted=1, instr_valid=0, imem_addr=14 and fetch_count frozen; after the redirect, halted=0 and instr_pc=0 is issued two edges later.
- **Wrap-around.** Stimulus: redirect to 8'd254 with non-halt words at 254, 255 and 0. Required response: instr_pc sequence 254, 255, 0, with no halt and no bubble at the wrap.
- **Asynchronous reset mid-run.** Stimulus: assert reset between clock edges while instr_valid=1. Required response: instr_valid=0, imem_addr=0, fetch_count=0 and state IDLE immediately; no fetch occurs until start.
